// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates two masters onto a single-port, registered-read memory,
// with an m1 bus lock capped at 16 grants. Define MEM_ARB_RR_EN for round-robin ties.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [9:0]  m0_addr,
  input  logic        m0_wr,
  input  logic [15:0] m0_wdata,
  output logic        m0_gnt,
  output logic [15:0] m0_rdata,
  output logic        m0_rvalid,
  input  logic        m1_req,
  input  logic [9:0]  m1_addr,
  input  logic        m1_wr,
  input  logic [15:0] m1_wdata,
  output logic        m1_gnt,
  output logic [15:0] m1_rdata,
  output logic        m1_rvalid,
  input  logic        m1_lock,
  output logic [9:0]  mem_addr,
  output logic        mem_wr,
  output logic [15:0] wr_data,
  input  logic [15:0] rd_data,
  output logic        lock_active
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_LOCK  = 1'b1;
  localparam logic [4:0] LOCK_MAX = 5'd16;

  logic [0:0] state_q, state_d;
  logic [4:0] lock_cnt_q, lock_cnt_d;
  logic       m1_block_q, m1_block_d;
  logic       tag_valid_q, tag_valid_d;
  logic       tag_owner_q, tag_owner_d;
  logic       gnt0, gnt1;
  logic       m1_elig;
  logic       tie_to_m1;

  assign m1_elig = m1_req & ~m1_block_q;

`ifdef MEM_ARB_RR_EN
  logic rr_ptr_q, rr_ptr_d;

  assign tie_to_m1 = rr_ptr_q;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == ST_IDLE && m0_req && m1_elig) begin
      rr_ptr_d = ~rr_ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  assign tie_to_m1 = 1'b0;
`endif

  // Grants are held off entirely while reset is asserted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst) begin
      if (state_q == ST_LOCK) begin
        gnt1 = m1_req;
      end else if (m0_req && m1_elig) begin
        gnt1 = tie_to_m1;
        gnt0 = ~tie_to_m1;
      end else begin
        gnt0 = m0_req;
        gnt1 = m1_elig;
      end
    end
  end

  assign m0_gnt = gnt0;
  assign m1_gnt = gnt1;

  always_comb begin
    mem_addr = '0;
    mem_wr   = 1'b0;
    wr_data  = '0;
    if (gnt1) begin
      mem_addr = m1_addr;
      mem_wr   = m1_wr;
      wr_data  = m1_wdata;
    end else if (gnt0) begin
      mem_addr = m0_addr;
      mem_wr   = m0_wr;
      wr_data  = m0_wdata;
    end
  end

  // A forced release at the 16th lock grant benches m1 for the following cycle.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    m1_block_d = 1'b0;
    if (state_q == ST_IDLE) begin
      if (gnt1 && m1_lock) begin
        state_d    = ST_LOCK;
        lock_cnt_d = '0;
      end
    end else begin
      if (gnt1 && lock_cnt_q != LOCK_MAX) begin
        lock_cnt_d = lock_cnt_q + 5'd1;
      end
      if (gnt1 && lock_cnt_d == LOCK_MAX) begin
        state_d    = ST_IDLE;
        m1_block_d = 1'b1;
      end else if (!m1_lock || !m1_req) begin
        state_d = ST_IDLE;
      end
    end
  end

  always_comb begin
    tag_valid_d = (gnt0 & ~m0_wr) | (gnt1 & ~m1_wr);
    tag_owner_d = gnt1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      lock_cnt_q  <= '0;
      m1_block_q  <= 1'b0;
      tag_valid_q <= 1'b0;
      tag_owner_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      m1_block_q  <= m1_block_d;
      tag_valid_q <= tag_valid_d;
      tag_owner_q <= tag_owner_d;
    end
  end

  assign m0_rvalid   = tag_valid_q & ~tag_owner_q;
  assign m1_rvalid   = tag_valid_q & tag_owner_q;
  assign m0_rdata    = m0_rvalid ? rd_data : '0;
  assign m1_rdata    = m1_rvalid ? rd_data : '0;
  assign lock_active = (state_q == ST_LOCK);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed bench for mem_arbiter against a
// cycle-level reference model of the arbitration rules and memory contents.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_wr, m0_gnt, m0_rvalid;
  logic [9:0]  m0_addr;
  logic [15:0] m0_wdata, m0_rdata;
  logic        m1_req, m1_wr, m1_gnt, m1_rvalid, m1_lock;
  logic [9:0]  m1_addr;
  logic [15:0] m1_wdata, m1_rdata;
  logic [9:0]  mem_addr;
  logic        mem_wr;
  logic [15:0] wr_data, rd_data;
  logic        lock_active;

  int testCount = 0;
  int failCount = 0;

  logic [15:0] envMem [0:511];
  logic [15:0] refMem [0:511];

  bit          refLocked;
  bit          refBlocked;
  bit          refFavourM1;
  int          refLockGrants;
  int          refPendOwner;
  logic [8:0]  refPendWord;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wr(m0_wr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wr(m1_wr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .m1_lock(m1_lock),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .wr_data(wr_data), .rd_data(rd_data),
    .lock_active(lock_active)
  );

  always #5 clk = ~clk;

  // Word-organised memory behind the arbiter: byte address bit 0 is dropped.
  always @(posedge clk) begin
    if (mem_wr) envMem[mem_addr[9:1]] <= wr_data;
    rd_data <= envMem[mem_addr[9:1]];
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s at %0t: observed %0h expected %0h", tag, $time, actual, expected);
    end
  endtask

  function automatic bit tieGoesToM1();
`ifdef MEM_ARB_RR_EN
    return refFavourM1;
`else
    return 1'b0;
`endif
  endfunction

  // Compares the current cycle against the model, then advances the model past the next edge.
  task automatic checkModel();
    bit          eg0, eg1, m1Ok, nextBlocked;
    logic [9:0]  eAddr;
    logic        eWr;
    logic [15:0] eWd, eRd;
    if (!rst) begin
      refLocked     = 1'b0;
      refBlocked    = 1'b0;
      refFavourM1   = 1'b0;
      refLockGrants = 0;
      refPendOwner  = -1;
    end
    eg0 = 1'b0;
    eg1 = 1'b0;
    if (rst) begin
      if (refLocked) begin
        eg1 = m1_req;
      end else begin
        m1Ok = m1_req && !refBlocked;
        if (m0_req && m1Ok) begin
          eg1 = tieGoesToM1();
          eg0 = !eg1;
          refFavourM1 = !refFavourM1;
        end else begin
          eg0 = m0_req;
          eg1 = m1Ok;
        end
      end
    end
    eAddr = eg1 ? m1_addr : (eg0 ? m0_addr : 10'h000);
    eWr   = eg1 ? m1_wr : (eg0 ? m0_wr : 1'b0);
    eWd   = eg1 ? m1_wdata : (eg0 ? m0_wdata : 16'h0000);
    eRd   = refMem[refPendWord];

    checkOutput("m0_gnt", m0_gnt, eg0);
    checkOutput("m1_gnt", m1_gnt, eg1);
    checkOutput("mem_addr", mem_addr, eAddr);
    checkOutput("mem_wr", mem_wr, eWr);
    checkOutput("wr_data", wr_data, eWd);
    checkOutput("lock_active", lock_active, refLocked);
    checkOutput("m0_rvalid", m0_rvalid, refPendOwner == 0);
    checkOutput("m1_rvalid", m1_rvalid, refPendOwner == 1);
    checkOutput("m0_rdata", m0_rdata, (refPendOwner == 0) ? eRd : 16'h0000);
    checkOutput("m1_rdata", m1_rdata, (refPendOwner == 1) ? eRd : 16'h0000);

    if ((eg0 || eg1) && eWr) refMem[eAddr[9:1]] = eWd;
    if ((eg0 || eg1) && !eWr) begin
      refPendOwner = eg1 ? 1 : 0;
      refPendWord  = eAddr[9:1];
    end else begin
      refPendOwner = -1;
    end

    nextBlocked = 1'b0;
    if (refLocked) begin
      if (eg1) refLockGrants++;
      if (eg1 && refLockGrants == 16) begin
        refLocked   = 1'b0;
        nextBlocked = 1'b1;
      end else if (!m1_lock || !m1_req) begin
        refLocked = 1'b0;
      end
    end else if (eg1 && m1_lock) begin
      refLocked     = 1'b1;
      refLockGrants = 0;
    end
    refBlocked = nextBlocked;
  endtask

  task automatic applyStimulus(input bit rstV,
                               input bit r0, input bit w0, input logic [9:0] a0, input logic [15:0] d0,
                               input bit r1, input bit w1, input logic [9:0] a1, input logic [15:0] d1,
                               input bit lk);
    @(posedge clk);
    #1;
    rst      = rstV;
    m0_req   = r0;
    m0_wr    = w0;
    m0_addr  = a0;
    m0_wdata = d0;
    m1_req   = r1;
    m1_wr    = w1;
    m1_addr  = a1;
    m1_wdata = d1;
    m1_lock  = lk;
    @(negedge clk);
    checkModel();
  endtask

  initial begin
    int lockCycles;
    logic [15:0] fillData;
    logic [9:0]  fillAddr;
    rst = 1'b0;
    m0_req = 1'b0; m0_wr = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_wr = 1'b0; m1_addr = '0; m1_wdata = '0; m1_lock = 1'b0;
    refPendWord  = '0;
    refPendOwner = -1;

    // Requests during reset must see no grants and all-zero outputs.
    applyStimulus(0, 1, 1, 10'h155, 16'hAAAA, 1, 0, 10'h2AA, 16'h5555, 1);
    checkOutput("reset_gnt", {m0_gnt, m1_gnt}, 2'b00);
    applyStimulus(0, 1, 0, 10'h003, 16'h0001, 1, 1, 10'h004, 16'h0002, 0);

    // Populate every memory word through alternating masters.
    for (int i = 0; i < 512; i++) begin
      fillData = 16'($urandom);
      fillAddr = {i[8:0], 1'b0};
      if (i[0]) applyStimulus(1, 0, 0, 10'h000, 16'h0000, 1, 1, fillAddr, fillData, 0);
      else      applyStimulus(1, 1, 1, fillAddr, fillData, 0, 0, 10'h000, 16'h0000, 0);
    end

    applyStimulus(1, 1, 1, 10'h100, 16'h1234, 0, 0, 10'h000, 16'h0000, 0);
    applyStimulus(1, 1, 0, 10'h100, 16'h0000, 0, 0, 10'h000, 16'h0000, 0);
    checkOutput("req028_gnt", m0_gnt, 1'b1);
    applyStimulus(1, 0, 0, 10'h000, 16'h0000, 0, 0, 10'h000, 16'h0000, 0);
    checkOutput("req028_rvalid", m0_rvalid, 1'b1);
    checkOutput("req028_rdata", m0_rdata, 16'h1234);
    checkOutput("req028_m1_rvalid", m1_rvalid, 1'b0);

    for (int k = 0; k < 8; k++) begin
      applyStimulus(1, 1, 0, 10'h010, 16'h0000, 1, 0, 10'h020, 16'h0000, 0);
`ifdef MEM_ARB_RR_EN
      checkOutput("req029_m0_gnt", m0_gnt, (k % 2) == 0);
      checkOutput("req029_m1_gnt", m1_gnt, (k % 2) == 1);
`else
      checkOutput("req029_m0_gnt", m0_gnt, 1'b1);
      checkOutput("req029_m1_gnt", m1_gnt, 1'b0);
`endif
    end

    applyStimulus(1, 0, 0, 10'h000, 16'h0000, 1, 1, 10'h004, 16'hBEEF, 0);
    checkOutput("req030_wr_first", mem_wr, 1'b1);
    applyStimulus(1, 1, 0, 10'h004, 16'h0000, 0, 0, 10'h000, 16'h0000, 0);
    checkOutput("req030_wr_second", mem_wr, 1'b0);
    checkOutput("req030_no_wr_rvalid", m1_rvalid, 1'b0);
    applyStimulus(1, 0, 0, 10'h000, 16'h0000, 0, 0, 10'h000, 16'h0000, 0);
    checkOutput("req030_rdata", m0_rdata, 16'hBEEF);

    // Lock burst: entry grant, 16 locked grants, forced release, m1 back afterwards.
    applyStimulus(1, 0, 0, 10'h000, 16'h0000, 1, 0, 10'h030, 16'h0000, 1);
    checkOutput("req031_entry_gnt", m1_gnt, 1'b1);
    lockCycles = 0;
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1, 1, 0, 10'h040, 16'h0000, 1, 0, 10'(10'h030 + 2 * k), 16'h0000, 1);
      checkOutput("req031_m0_held", m0_gnt, 1'b0);
      if (m1_gnt && lock_active) lockCycles++;
    end
    checkOutput("req031_lock_cycles", lockCycles, 16);
    applyStimulus(1, 1, 0, 10'h040, 16'h0000, 1, 0, 10'h050, 16'h0000, 1);
    checkOutput("req031_m0_gnt17", m0_gnt, 1'b1);
    checkOutput("req031_m1_gnt17", m1_gnt, 1'b0);
    checkOutput("req031_unlocked17", lock_active, 1'b0);
    applyStimulus(1, 0, 0, 10'h000, 16'h0000, 1, 0, 10'h052, 16'h0000, 1);
    checkOutput("req031_m1_gnt18", m1_gnt, 1'b1);
    applyStimulus(1, 0, 0, 10'h000, 16'h0000, 0, 0, 10'h000, 16'h0000, 0);

    applyStimulus(1, 0, 0, 10'h000, 16'h0000, 1, 0, 10'h0AA, 16'h0000, 0);
    checkOutput("req032_gnt", m1_gnt, 1'b1);
    applyStimulus(0, 1, 0, 10'h011, 16'h0000, 1, 0, 10'h0AA, 16'h0000, 0);
    checkOutput("req032_rvalid", m1_rvalid, 1'b0);
    checkOutput("req032_outputs", {m0_gnt, m1_gnt, mem_wr, mem_addr, wr_data}, '0);
    applyStimulus(0, 0, 0, 10'h000, 16'h0000, 0, 0, 10'h000, 16'h0000, 0);
    applyStimulus(1, 0, 0, 10'h000, 16'h0000, 1, 0, 10'h0AC, 16'h0000, 0);
    checkOutput("req032_first_gnt", m1_gnt, 1'b1);

    for (int c = 0; c < 3000; c++) begin
      applyStimulus($urandom_range(0, 199) != 0,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    10'($urandom), 16'($urandom),
                    $urandom_range(0, 9) < 8, $urandom_range(0, 3) == 0,
                    10'($urandom), 16'($urandom),
                    $urandom_range(0, 15) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
